mux_tree_pipe: RTL and testbench
================================

// Module: mux_tree_pipe
// PURPOSE
//  Parametrised NUM_IN:1 multiplexer of WIDTH-bit words, built as a binary tree
//  of 2:1 levels with one pipeline register per level and valid/ready flow control.
//  It is the pipelined, flow-controlled successor to the combinational 2:1/4:1 mux
//  family. It sits between wide parallel sources and a single-lane consumer that
//  may back-pressure.
// PARAMETERS
//  WIDTH   8   bits per input word (>=1)
//  NUM_IN  8   number of input words; power of two, >=2
//  SEL_W   $clog2(NUM_IN)  select width; derived, do not override
// PORTS
//  clk        in   1             rising-edge clock, single clock domain
//  rst_n      in   1             asynchronous, active-low reset
//  in_data    in   NUM_IN*WIDTH  word i = in_data[i*WIDTH +: WIDTH]
//  in_sel     in   SEL_W         index of word to forward
//  in_valid   in   1             in_data/in_sel valid this cycle
//  in_ready   out  1             block accepts in_* this cycle
//  out_data   out  WIDTH         selected word
//  out_valid  out  1             out_data valid
//  out_ready  in   1             consumer accepts out_data this cycle
// BEHAVIOUR
//  - Levels: LEVELS = SEL_W. Level k (k=0..SEL_W-1) halves the word count using
//    sel bit k (LSB first): pair (2j, 2j+1) -> j; bit=0 picks 2j, bit=1 picks 2j+1.
//    Remaining sel bits [SEL_W-1:k+1] are registered alongside the data of level k.
//  - Each level has a register stage {valid_k, data_k, sel_k}. The last stage drives
//    out_valid/out_data.
//  - Transfer rule: in and out are handshakes; a word moves when valid && ready.
//  - Per-stage ready: rdy_k = !valid_k || rdy_{k+1}; rdy_LEVELS = out_ready.
//    in_ready = rdy_0. This is a combinational path from out_ready to in_ready
//    (full-throughput chain); no skid buffer.
//  - Stage k loads when rdy_k: valid_k <= valid_{k-1} (in_valid for k=0), data and
//    sel follow. When !rdy_k, the stage holds all contents unchanged.
//  - Latency: SEL_W cycles from an accepted input to out_valid when not stalled.
//    Throughput: 1 word/cycle when out_ready is held high.
//  - Ordering: words leave in acceptance order; none is dropped or duplicated.
//  - Bubbles: an invalid slot is overwritten by upstream data even while downstream
//    stalls, so a bubble never blocks upstream.
//  - Stability: while out_valid && !out_ready, out_data holds steady.
//  - Data registers load only when the incoming valid is 1. Idle data is don't-care
//    but is never X after reset.
//  - Reset (rst_n low, async): all valid_k=0, data_k=0, sel_k=0.
//    Outputs: out_valid=0, out_data=0, in_ready=1.
//    Reset asserted mid-stream discards all in-flight words. The first word is
//    accepted on the first rising edge after rst_n deasserts.
//  - in_sel and in_data are sampled only when in_valid && in_ready; values at other
//    times are ignored.
//  - NUM_IN=2 degenerates to a single registered level with latency 1.
// STRUCTURE
//  - Shared package mux_pkg: clog2 function, and the assertion macro that checks
//    NUM_IN is a power of two >=2 at elaboration.
//  - Sub-module mux_pipe_stage #(WIDTH, N_IN, SELR_W): one tree level.
//    It contains N_IN/2 2:1 muxes, the stage register, and the rdy logic.
//  - Top instantiates SEL_W stages with a generate loop.
// TESTING
//  1 Reset: rst_n=0 for 3 clk -> out_valid=0, out_data=0, in_ready=1.
//    Release; no activity -> outputs unchanged.
//  2 Sweep: NUM_IN=8, WIDTH=8, word i=8'hA0+i, out_ready=1, send sel=0..7 back to back
//    -> out_data=A0..A7 in order, first at cycle 3 after accept, no gaps.
//  3 Back-pressure: fill the pipe with sel=5,2,7, hold out_ready=0 for 10 cycles
//    -> out_data=A5 stable, in_ready=0 once 3 words are held.
//    Release -> A5,A2,A7 on consecutive cycles.
//  4 Bubble collapse: single word sel=3, out_ready=0, then in_valid pulses
//    -> in_ready stays 1 until all 3 stages hold valid words; no word lost.
//  5 Mid-stream reset: 3 words in flight, pulse rst_n low between edges
//    -> out_valid=0 immediately. After release, the next word (sel=6) emerges alone.
//  6 Random: random in_valid/out_ready (50%), NUM_IN in {2,4,16}, WIDTH=1 and 32
//    -> output stream matches the scoreboard model exactly.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared helpers for the pipelined mux tree: select-width function and the
// elaboration-time check on the input count.
`ifndef MUX_PKG_SV
`define MUX_PKG_SV

// Placed inside a module body; flags a non-power-of-two (or <2) input count.
`define MUX_ASSERT_POW2(n) \
   if (((n) < 2) || (((n) & ((n) - 1)) != 0)) begin : g_bad_num_in \
      $error("NUM_IN must be a power of two >= 2"); \
   end

package mux_pkg;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

`endif

// File: rtl/mux_pipe_stage.sv
// One level of the mux tree: N_IN/2 2:1 muxes steered by sel bit 0, a register
// stage holding {valid, data, upper sel bits}, and the stage ready term.
module mux_pipe_stage #(
   parameter int WIDTH  = 8,
   parameter int N_IN   = 2,
   parameter int SELR_W = 1,
   localparam int SELO_W = (SELR_W > 1) ? SELR_W - 1 : 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        valid_i,
   input  logic [N_IN*WIDTH-1:0]       data_i,
   input  logic [SELR_W-1:0]           sel_i,
   input  logic                        rdy_nxt_i,
   output logic                        rdy_o,
   output logic                        valid_o,
   output logic [(N_IN/2)*WIDTH-1:0]   data_o,
   output logic [SELO_W-1:0]           sel_o
);

   localparam int N_OUT = N_IN / 2;

   logic                     valid_q;
   logic [N_OUT*WIDTH-1:0]   data_d, data_q;
   logic [SELO_W-1:0]        sel_d, sel_q;

   // A stage can take a new word if it is empty or its content leaves this cycle.
   assign rdy_o = !valid_q || rdy_nxt_i;

   always_comb begin
      data_d = '0;
      for (int j = 0; j < N_OUT; j++) begin
         data_d[j*WIDTH +: WIDTH] = sel_i[0] ? data_i[(2*j+1)*WIDTH +: WIDTH]
                                             : data_i[(2*j)*WIDTH +: WIDTH];
      end
   end

   generate
      if (SELR_W > 1) begin : g_sel_fwd
         assign sel_d = sel_i[SELR_W-1:1];
      end else begin : g_sel_last
         assign sel_d = '0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sel_q   <= '0;
      end else if (rdy_o) begin
         valid_q <= valid_i;
         if (valid_i) begin
            data_q <= data_d;
            sel_q  <= sel_d;
         end
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign sel_o   = sel_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// NUM_IN:1 word mux built as a binary tree of registered 2:1 levels with a
// valid/ready chain; one level per select bit, LSB resolved first.
module mux_tree_pipe
   import mux_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 8,
   parameter int SEL_W  = clog2(NUM_IN)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_IN*WIDTH-1:0]  in_data,
   input  logic [SEL_W-1:0]         in_sel,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready
);

   `MUX_ASSERT_POW2(NUM_IN)

   generate
      for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
         localparam int NI  = NUM_IN >> k;
         localparam int SW  = SEL_W - k;
         localparam int SOW = (SW > 1) ? SW - 1 : 1;

         logic                     v_in, v_q, rdy, rdy_nxt;
         logic [NI*WIDTH-1:0]      d_in;
         logic [SW-1:0]            s_in;
         logic [(NI/2)*WIDTH-1:0]  d_q;
         logic [SOW-1:0]           s_q;

         if (k == 0) begin : g_src
            assign v_in = in_valid;
            assign d_in = in_data;
            assign s_in = in_sel;
         end else begin : g_chain
            assign v_in = g_lvl[k-1].v_q;
            assign d_in = g_lvl[k-1].d_q;
            assign s_in = g_lvl[k-1].s_q;
         end

         // Ready ripples back combinationally from the consumer for full throughput.
         if (k == SEL_W - 1) begin : g_sink
            assign rdy_nxt = out_ready;
         end else begin : g_down
            assign rdy_nxt = g_lvl[k+1].rdy;
         end

         mux_pipe_stage #(
            .WIDTH  (WIDTH),
            .N_IN   (NI),
            .SELR_W (SW)
         ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .valid_i   (v_in),
            .data_i    (d_in),
            .sel_i     (s_in),
            .rdy_nxt_i (rdy_nxt),
            .rdy_o     (rdy),
            .valid_o   (v_q),
            .data_o    (d_q),
            .sel_o     (s_q)
         );
      end
   endgenerate

   assign in_ready  = g_lvl[0].rdy;
   assign out_valid = g_lvl[SEL_W-1].v_q;
   assign out_data  = g_lvl[SEL_W-1].d_q;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed and randomised checks of mux_tree_pipe on several geometries.
module tb_mux_tree_pipe;

   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // main 8x8 instance
   logic [63:0] m_data;
   logic [2:0]  m_sel;
   logic        m_iv, m_ir, m_ov, m_ordy;
   logic [7:0]  m_od;

   mux_tree_pipe #(.WIDTH(8), .NUM_IN(8)) u_main (
      .clk(clk), .rst_n(rst_n), .in_data(m_data), .in_sel(m_sel), .in_valid(m_iv),
      .in_ready(m_ir), .out_data(m_od), .out_valid(m_ov), .out_ready(m_ordy)
   );

   // random-test instances: (NUM_IN,WIDTH) = (2,32), (4,1), (16,32)
   logic [511:0] rd_data [3];
   logic [3:0]   rd_sel  [3];
   logic         rd_iv   [3];
   logic         rd_ordy [3];
   logic         rd_ir   [3];
   logic         rd_ov   [3];
   logic [31:0]  rd_od   [3];
   logic [31:0]  a_od, c_od;
   logic         b_od;
   logic         a_ir, a_ov, b_ir, b_ov, c_ir, c_ov;

   mux_tree_pipe #(.WIDTH(32), .NUM_IN(2)) u_a (
      .clk(clk), .rst_n(rst_n), .in_data(rd_data[0][63:0]), .in_sel(rd_sel[0][0:0]),
      .in_valid(rd_iv[0]), .in_ready(a_ir), .out_data(a_od), .out_valid(a_ov),
      .out_ready(rd_ordy[0])
   );
   mux_tree_pipe #(.WIDTH(1), .NUM_IN(4)) u_b (
      .clk(clk), .rst_n(rst_n), .in_data(rd_data[1][3:0]), .in_sel(rd_sel[1][1:0]),
      .in_valid(rd_iv[1]), .in_ready(b_ir), .out_data(b_od), .out_valid(b_ov),
      .out_ready(rd_ordy[1])
   );
   mux_tree_pipe #(.WIDTH(32), .NUM_IN(16)) u_c (
      .clk(clk), .rst_n(rst_n), .in_data(rd_data[2]), .in_sel(rd_sel[2]),
      .in_valid(rd_iv[2]), .in_ready(c_ir), .out_data(c_od), .out_valid(c_ov),
      .out_ready(rd_ordy[2])
   );

   always_comb begin
      rd_od[0] = a_od;
      rd_od[1] = {31'b0, b_od};
      rd_od[2] = c_od;
      rd_ir[0] = a_ir;
      rd_ir[1] = b_ir;
      rd_ir[2] = c_ir;
      rd_ov[0] = a_ov;
      rd_ov[1] = b_ov;
      rd_ov[2] = c_ov;
   end

   task automatic drv(input logic v, input logic [2:0] s, input logic r);
      @(negedge clk);
      m_iv   = v;
      m_sel  = s;
      m_ordy = r;
      #1;
   endtask

   int          ni [3] = '{2, 4, 16};
   int          ww [3] = '{32, 1, 32};
   logic [31:0] sb [3][0:1023];
   int          wr [3];
   int          rp [3];

   initial begin
      logic [511:0] sh;
      logic [31:0]  mask;
      logic [2:0]   s3;

      rst_n  = 1'b0;
      m_iv   = 1'b0;
      m_sel  = '0;
      m_ordy = 1'b0;
      for (int i = 0; i < 8; i++) m_data[i*8 +: 8] = 8'hA0 + 8'(i);
      for (int c = 0; c < 3; c++) begin
         rd_data[c] = '0;
         rd_sel[c]  = '0;
         rd_iv[c]   = 1'b0;
         rd_ordy[c] = 1'b0;
         wr[c] = 0;
         rp[c] = 0;
      end

      // 1: reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ov", 32'(m_ov), 32'd0);
      chk("rst_od", 32'(m_od), 32'd0);
      chk("rst_ir", 32'(m_ir), 32'd1);
      rst_n = 1'b1;
      repeat (3) drv(0, 0, 0);
      chk("idle_ov", 32'(m_ov), 32'd0);
      chk("idle_od", 32'(m_od), 32'd0);
      chk("idle_ir", 32'(m_ir), 32'd1);

      // 2: sweep, out_ready high
      for (int i = 0; i < 12; i++) begin
         s3 = 3'(i);
         drv(i < 8, s3, 1);
         if (i < 8) chk("sweep_ir", 32'(m_ir), 32'd1);
         if (i >= 3 && i < 11) begin
            chk($sformatf("sweep_ov%0d", i), 32'(m_ov), 32'd1);
            chk($sformatf("sweep_od%0d", i), 32'(m_od), 32'hA0 + 32'(i - 3));
         end else begin
            chk($sformatf("sweep_ov%0d", i), 32'(m_ov), 32'd0);
         end
      end

      // 3: back-pressure with 5,2,7
      drv(1, 5, 0);
      chk("bp_ir0", 32'(m_ir), 32'd1);
      drv(1, 2, 0);
      chk("bp_ir1", 32'(m_ir), 32'd1);
      drv(1, 7, 0);
      chk("bp_ir2", 32'(m_ir), 32'd1);
      for (int i = 0; i < 10; i++) begin
         drv(0, 0, 0);
         chk("bp_hold_ov", 32'(m_ov), 32'd1);
         chk("bp_hold_od", 32'(m_od), 32'hA5);
         chk("bp_hold_ir", 32'(m_ir), 32'd0);
      end
      drv(0, 0, 1);
      chk("bp_rel_od0", 32'(m_od), 32'hA5);
      chk("bp_rel_ov0", 32'(m_ov), 32'd1);
      drv(0, 0, 1);
      chk("bp_rel_od1", 32'(m_od), 32'hA2);
      chk("bp_rel_ov1", 32'(m_ov), 32'd1);
      drv(0, 0, 1);
      chk("bp_rel_od2", 32'(m_od), 32'hA7);
      chk("bp_rel_ov2", 32'(m_ov), 32'd1);
      drv(0, 0, 1);
      chk("bp_empty", 32'(m_ov), 32'd0);

      // 4: bubble collapse under stall
      drv(1, 3, 0);
      chk("bub_ir0", 32'(m_ir), 32'd1);
      drv(0, 0, 0);
      chk("bub_ir1", 32'(m_ir), 32'd1);
      drv(1, 1, 0);
      chk("bub_ir2", 32'(m_ir), 32'd1);
      drv(0, 0, 0);
      chk("bub_ir3", 32'(m_ir), 32'd1);
      drv(1, 4, 0);
      chk("bub_ir4", 32'(m_ir), 32'd1);
      drv(0, 0, 0);
      chk("bub_full_ir", 32'(m_ir), 32'd0);
      chk("bub_full_od", 32'(m_od), 32'hA3);
      drv(0, 0, 1);
      chk("bub_od0", 32'(m_od), 32'hA3);
      drv(0, 0, 1);
      chk("bub_od1", 32'(m_od), 32'hA1);
      chk("bub_ov1", 32'(m_ov), 32'd1);
      drv(0, 0, 1);
      chk("bub_od2", 32'(m_od), 32'hA4);
      chk("bub_ov2", 32'(m_ov), 32'd1);
      drv(0, 0, 1);
      chk("bub_empty", 32'(m_ov), 32'd0);

      // 5: mid-stream async reset
      drv(1, 1, 1);
      drv(1, 2, 1);
      drv(1, 3, 1);
      drv(0, 0, 1);
      chk("mrst_pre_ov", 32'(m_ov), 32'd1);
      chk("mrst_pre_od", 32'(m_od), 32'hA1);
      rst_n = 1'b0;
      #1;
      chk("mrst_ov", 32'(m_ov), 32'd0);
      chk("mrst_od", 32'(m_od), 32'd0);
      chk("mrst_ir", 32'(m_ir), 32'd1);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drv(i == 0, 6, 1);
         chk($sformatf("mrst_ov%0d", i), 32'(m_ov), (i == 3) ? 32'd1 : 32'd0);
         if (i == 3) chk("mrst_od", 32'(m_od), 32'hA6);
      end

      // 6: random traffic against a FIFO scoreboard
      for (int cyc = 0; cyc < 520; cyc++) begin
         @(negedge clk);
         for (int c = 0; c < 3; c++) begin
            for (int w = 0; w < 16; w++) rd_data[c][w*32 +: 32] = $urandom;
            rd_sel[c]  = 4'($urandom_range(0, ni[c] - 1));
            rd_iv[c]   = (cyc < 500) ? 1'($urandom_range(0, 1)) : 1'b0;
            rd_ordy[c] = (cyc < 500) ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         #1;
         for (int c = 0; c < 3; c++) begin
            mask = (ww[c] == 32) ? 32'hFFFF_FFFF : ((32'd1 << ww[c]) - 32'd1);
            if (rd_ov[c] && rd_ordy[c]) begin
               if (rp[c] == wr[c]) begin
                  chk($sformatf("rnd%0d_extra", c), 32'd1, 32'd0);
               end else begin
                  chk($sformatf("rnd%0d_data", c), rd_od[c], sb[c][rp[c] % 1024]);
                  rp[c]++;
               end
            end
            if (rd_iv[c] && rd_ir[c]) begin
               sh = rd_data[c] >> (int'(rd_sel[c]) * ww[c]);
               sb[c][wr[c] % 1024] = sh[31:0] & mask;
               wr[c]++;
            end
         end
      end
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("rnd%0d_drained", c), 32'(rp[c]), 32'(wr[c]));
         chk($sformatf("rnd%0d_final_ov", c), 32'(rd_ov[c]), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
